// File: rtl/log_tick_gen.sv
// Move-strobe prescaler and LFSR lane picker for the log mover.
// Optional macro LOG_NO_REPEAT_EN: reject a candidate equal to the current lane.
module log_tick_gen #(
  parameter logic [23:0] TICK_DIV  = 24'd500000,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned MAX_TRIES = 15
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        enable,
  input  logic [1:0]  speed_sel,
  input  logic [10:0] ObjectStartX,
  output logic        timer_done,
  output logic [3:0]  random_1_12,
  output logic        draw_busy
);

  localparam logic [15:0] SeedEff = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam int unsigned TryW = $clog2(MAX_TRIES + 2);

  typedef enum logic [1:0] {StReady, StDraw, StCommit} state_e;

  state_e          state_q, state_d;
  logic [23:0]     cnt_q, cnt_d;
  logic            tick_q, tick_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [TryW-1:0] try_q, try_d;
  logic            pend_q, pend_d;
  logic [3:0]      rnd_q, rnd_d;
  logic [3:0]      cand_q, cand_d;
  logic            busy_q, busy_d;

  logic [23:0] div_m1;
  logic        consume;
  logic [15:0] lfsr_step;
  logic [3:0]  fallback;
  logic        in_range;
  logic        accept;

  // Prescaler: a count beyond the new terminal value (after a speed change) wraps silently.
  always_comb begin
    div_m1 = (TICK_DIV >> speed_sel) - 24'd1;
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (enable) begin
      if (cnt_q == div_m1) begin
        cnt_d  = '0;
        tick_d = 1'b1;
      end else if (cnt_q > div_m1) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 24'd1;
      end
    end
  end

  always_comb begin
    consume   = tick_q && (ObjectStartX == 11'd0);
    lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    fallback  = (rnd_q % 4'd12) + 4'd1;
    in_range  = (lfsr_step[3:0] >= 4'd1) && (lfsr_step[3:0] <= 4'd12);
`ifdef LOG_NO_REPEAT_EN
    accept    = in_range && (lfsr_step[3:0] != rnd_q);
`else
    accept    = in_range;
`endif
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    try_d   = try_q;
    pend_d  = pend_q;
    rnd_d   = rnd_q;
    cand_d  = cand_q;
    unique case (state_q)
      StReady: begin
        if (consume) begin
          state_d = StDraw;
          try_d   = '0;
        end
      end
      StDraw: begin
        lfsr_d = lfsr_step;
        pend_d = pend_q | consume;
        if (try_q >= TryW'(MAX_TRIES)) begin
          cand_d  = fallback;
          state_d = StCommit;
        end else if (accept) begin
          cand_d  = lfsr_step[3:0];
          state_d = StCommit;
        end else begin
          try_d = try_q + TryW'(1);
        end
      end
      StCommit: begin
        // The mover samples the lane on strobe cycles, so never load during one.
        if (tick_q) begin
          pend_d = pend_q | consume;
        end else begin
          rnd_d = cand_q;
          if (pend_q) begin
            state_d = StDraw;
            try_d   = '0;
            pend_d  = 1'b0;
          end else begin
            state_d = StReady;
          end
        end
      end
      default: state_d = StReady;
    endcase
    busy_d = (state_d != StReady);
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= StReady;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      lfsr_q  <= SeedEff;
      try_q   <= '0;
      pend_q  <= 1'b0;
      rnd_q   <= 4'd1;
      cand_q  <= 4'd1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      lfsr_q  <= lfsr_d;
      try_q   <= try_d;
      pend_q  <= pend_d;
      rnd_q   <= rnd_d;
      cand_q  <= cand_d;
      busy_q  <= busy_d;
    end
  end

  assign timer_done  = tick_q;
  assign random_1_12 = rnd_q;
  assign draw_busy   = busy_q;

endmodule

// File: tb/tb_log_tick_gen.sv
// Bench for log_tick_gen: two instances (normal draw and forced fallback) against a
// draw-level reference model, plus directed literal expectations.
module tb_log_tick_gen;

  logic        CLK = 1'b0;
  logic        RESETn;
  logic        enable;
  logic [1:0]  speed_sel;
  logic [10:0] x [2];
  logic        td [2];
  logic [3:0]  rnd [2];
  logic        busy [2];

  always #5 CLK = ~CLK;

  log_tick_gen #(.TICK_DIV(24'd8), .SEED(16'hACE1), .MAX_TRIES(15)) u_dut0 (
    .CLK(CLK), .RESETn(RESETn), .enable(enable), .speed_sel(speed_sel),
    .ObjectStartX(x[0]), .timer_done(td[0]), .random_1_12(rnd[0]), .draw_busy(busy[0])
  );

  log_tick_gen #(.TICK_DIV(24'd8), .SEED(16'hACE1), .MAX_TRIES(0)) u_dut1 (
    .CLK(CLK), .RESETn(RESETn), .enable(enable), .speed_sel(speed_sel),
    .ObjectStartX(x[1]), .timer_done(td[1]), .random_1_12(rnd[1]), .draw_busy(busy[1])
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  int unsigned maxt [2] = '{15, 0};
  int          m_cnt [2];
  bit          m_td [2];
  logic [3:0]  m_rnd [2];
  bit          m_busy [2];
  logic [15:0] m_lfsr [2];
  int          m_left [2];
  logic [3:0]  m_val [2];
  bit          m_pend [2];
  bit          m_commit [2];

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic bit lane_ok(input logic [3:0] c, input logic [3:0] cur);
    bit r;
    r = (c >= 4'd1) && (c <= 4'd12);
`ifdef LOG_NO_REPEAT_EN
    r = r && (c != cur);
`endif
    return r;
  endfunction

  // Resolve a whole draw up front: outcome value and number of draw cycles.
  task automatic start_draw(input int i);
    logic [15:0] l;
    int n;
    l = m_lfsr[i];
    n = 0;
    forever begin
      l = lstep(l);
      n++;
      if (n - 1 >= int'(maxt[i])) begin
        m_val[i] = 4'((int'(m_rnd[i]) % 12) + 1);
        break;
      end
      if (lane_ok(l[3:0], m_rnd[i])) begin
        m_val[i] = l[3:0];
        break;
      end
    end
    m_lfsr[i] = l;
    m_left[i] = n;
    m_busy[i] = 1'b1;
  endtask

  initial forever begin
    @(posedge CLK or negedge RESETn);
    for (int i = 0; i < 2; i++) begin
      if (!RESETn) begin
        m_cnt[i] = 0; m_td[i] = 0; m_rnd[i] = 4'd1; m_busy[i] = 0;
        m_lfsr[i] = 16'hACE1; m_left[i] = 0; m_val[i] = 4'd1; m_pend[i] = 0;
        m_commit[i] = 0;
      end else begin
        bit cons, td_old;
        int div;
        cons   = m_td[i] && (x[i] == 11'd0);
        td_old = m_td[i];
        m_commit[i] = 0;
        m_td[i] = 0;
        if (enable) begin
          div = 8 >> speed_sel;
          if (m_cnt[i] == div - 1) begin m_cnt[i] = 0; m_td[i] = 1; end
          else if (m_cnt[i] > div - 1) m_cnt[i] = 0;
          else m_cnt[i]++;
        end
        if (m_busy[i]) begin
          if (m_left[i] > 0) begin
            m_left[i]--;
            if (cons) m_pend[i] = 1;
          end else if (td_old) begin
            if (cons) m_pend[i] = 1;
          end else begin
            m_rnd[i] = m_val[i];
            m_commit[i] = 1;
            if (m_pend[i]) begin
              m_pend[i] = 0;
              start_draw(i);
            end else begin
              m_busy[i] = 0;
            end
          end
        end else if (cons) begin
          start_draw(i);
        end
      end
    end
  end

  // ---------------- compare process ----------------
  bit         prev_ok = 0;
  bit         prev_td [2];
  logic [3:0] prev_rnd [2];
  int         commits1 = 0;
  bit [12:0]  seen0 = '0;

  initial forever begin
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("timer_done[%0d]", i), int'(td[i]), int'(m_td[i]));
      chk($sformatf("random_1_12[%0d]", i), int'(rnd[i]), int'(m_rnd[i]));
      chk($sformatf("draw_busy[%0d]", i), int'(busy[i]), int'(m_busy[i]));
      chk($sformatf("lane_range[%0d]", i), int'(rnd[i] >= 4'd1 && rnd[i] <= 4'd12), 1);
      if (RESETn && prev_ok && prev_td[i])
        chk($sformatf("stable_on_strobe[%0d]", i), int'(rnd[i]), int'(prev_rnd[i]));
    end
    if (!RESETn) begin
      prev_ok  = 0;
      commits1 = 0;
    end else begin
      if (m_commit[0]) begin
        seen0[rnd[0]] = 1'b1;
`ifdef LOG_NO_REPEAT_EN
        if (prev_ok) chk("no_repeat", int'(rnd[0] != prev_rnd[0]), 1);
`endif
      end
      if (m_commit[1]) commits1++;
      prev_ok = 1;
    end
    for (int i = 0; i < 2; i++) begin
      prev_td[i]  = td[i];
      prev_rnd[i] = rnd[i];
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_strobe0();
    int got;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (td[0]) begin got = 1; break; end
    end
    chk("wait_strobe", got, 1);
  endtask

  initial begin
    int pulses, lat;
    RESETn = 1'b0; enable = 1'b1; speed_sel = 2'd0; x[0] = 11'd100; x[1] = 11'd100;
    repeat (3) @(negedge CLK);
    chk("reset_td", int'(td[0]), 0);
    chk("reset_rnd", int'(rnd[0]), 1);
    chk("reset_busy", int'(busy[0]), 0);
    chk("reset_rnd1", int'(rnd[1]), 1);
    RESETn = 1'b1;

    // First strobe 8 cycles after release, then every 8, one cycle wide.
    for (int i = 1; i <= 24; i++) begin
      @(negedge CLK);
      chk("pulse_pattern_div8", int'(td[0]), int'(i % 8 == 0));
    end

    speed_sel = 2'd2;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin @(negedge CLK); pulses += int'(td[0]); end
    chk("pulses_div2", pulses, 10);

    enable = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin @(negedge CLK); pulses += int'(td[0]); end
    chk("pulses_paused", pulses, 0);
    enable = 1'b1;
    repeat (5) @(negedge CLK);
    speed_sel = 2'd0;

    // First consume: SEED 0xACE1 steps to 0x59C3, nibble 3 is accepted.
    wait_strobe0();
    x[0] = 11'd0; x[1] = 11'd0;
    @(negedge CLK);
    x[0] = 11'd100; x[1] = 11'd100;
    chk("busy_after_consume0", int'(busy[0]), 1);
    chk("busy_after_consume1", int'(busy[1]), 1);
    lat = 99;
    for (int i = 1; i <= 30; i++) begin
      @(negedge CLK);
      if (rnd[0] != 4'd1) begin lat = i; break; end
    end
    chk("first_draw_value", int'(rnd[0]), 3);
    chk("first_draw_latency_ok", int'(lat <= 17), 1);
    chk("first_fallback_value", int'(rnd[1]), 2);

    // Back-to-back consumes while busy.
    speed_sel = 2'd2;
    x[0] = 11'd0; x[1] = 11'd0;
    repeat (12) @(negedge CLK);
    x[0] = 11'd100; x[1] = 11'd100;
    repeat (40) @(negedge CLK);

    for (int c = 0; c < 8000; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 2; i++)
        x[i] = ($urandom_range(0, 1) == 0) ? 11'd0 : 11'($urandom_range(1, 2047));
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 63) == 0) speed_sel = 2'($urandom_range(0, 3));
      if (c == 4000) begin
        #2 RESETn = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #2 RESETn = 1'b1;
      end
    end

    x[0] = 11'd100; x[1] = 11'd100; enable = 1'b1;
    repeat (40) @(negedge CLK);
    chk("fallback_sequence", int'(rnd[1]), (commits1 % 12) + 1);
    chk("all_lanes_seen", $countones(seen0[12:1]), 12);
    chk("fallback_commits_made", int'(commits1 > 24), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
